// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit for the E stage, holding the
// architectural HI/LO registers.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; clears HI/LO and aborts any operation
//   A, B    forwarded rs / rt operands (32 bit)
//   MDCtrl  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//           6 mtlo, 7 madd, 8 maddu, 9 msub (7-9 only with MDU_MADD_EN),
//           10-15 no-op
//   Start   one-cycle qualifier for MDCtrl
//   Busy    high for exactly MULT_CYCLES / DIV_CYCLES cycles per long op
//   HI, LO  committed HI/LO values
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub
// (64-bit accumulate into {HI,LO}). Without it, ops 7-9 are no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDCtrl,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  state_t        state;
  md_req_t       req;
  logic [CW-1:0] cnt;

  function automatic logic is_long(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB:         is_long = 1'b1;
`endif
      default:                            is_long = 1'b0;
    endcase
  endfunction

  // Result datapath works off the latched request; it is only sampled on the
  // final RUN cycle, so it has the whole busy period to settle.
  logic signed [63:0] sa64, sb64;
  logic        [63:0] prod_s, prod_u, res;
  logic               div_s, a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    sa64   = {{32{req.a[31]}}, req.a};
    sb64   = {{32{req.b[31]}}, req.b};
    prod_s = sa64 * sb64;
    prod_u = {32'd0, req.a} * {32'd0, req.b};

    // Signed divide on magnitudes, then fix signs. 0x80000000 / -1 falls out
    // naturally: magnitude 0x80000000 negated is still 0x80000000, rem 0.
    div_s  = (req.op == OP_DIV);
    a_neg  = div_s & req.a[31];
    b_neg  = div_s & req.b[31];
    a_mag  = a_neg ? (~req.a + 32'd1) : req.a;
    b_mag  = b_neg ? (~req.b + 32'd1) : req.b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    // HI/LO cannot change while RUN, so the current {HI,LO} equals the value
    // at Start and serves as both the "unchanged" result and the madd base.
    res = {HI, LO};
    case (req.op)
      OP_MULT:          res = prod_s;
      OP_MULTU:         res = prod_u;
      OP_DIV, OP_DIVU:  if (req.b != 32'd0) res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD:          res = {HI, LO} + prod_s;
      OP_MADDU:         res = {HI, LO} + prod_u;
      OP_MSUB:          res = {HI, LO} - prod_s;
`endif
      default:          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= '0;
      req   <= '0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (is_long(MDCtrl)) begin
              req   <= '{op: MDCtrl, a: A, b: B};
              cnt   <= (MDCtrl == OP_DIV || MDCtrl == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
              state <= RUN;
              Busy  <= 1'b1;
            end else if (MDCtrl == OP_MTHI) begin
              HI <= A;
            end else if (MDCtrl == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          // Start is ignored here; only the countdown and final commit act.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            HI    <= res[63:32];
            LO    <= res[31:0];
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDCtrl;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDCtrl(MDCtrl),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] op, input logic [31:0] a, b, pre_hi, pre_lo,
                     exp_hi, exp_lo, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.pre_hi = pre_hi; v.pre_lo = pre_lo;
    v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.cyc = cyc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and count how many sampled cycles Busy stays high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, output int cyc);
    @(negedge clk);
    MDCtrl = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDCtrl = 4'd0;
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, l);
    int c;
    run_op(4'd5, h, 32'd0, c);
    run_op(4'd6, l, 32'd0, c);
  endtask

  // Reference model: plain 64-bit / int arithmetic on the architectural rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                input logic [31:0] hi_in, lo_in,
                                output logic [31:0] hi_o, lo_o, output int cyc);
    logic [63:0] acc, pu;
    longint      ps;
    int          sa, sb;
    acc = {hi_in, lo_in};
    sa  = a;
    sb  = b;
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'd0, a} * {32'd0, b};
    cyc = 0;
    case (op)
      4'd1: begin acc = 64'(ps); cyc = MC; end
      4'd2: begin acc = pu;      cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (sb != 0) begin
          if (sa == 32'sh80000000 && sb == -1) acc = {32'd0, 32'h80000000};
          else acc = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      4'd4: begin
        cyc = DC;
        if (b != 0) acc = {a % b, a / b};
      end
      4'd5: acc[63:32] = a;
      4'd6: acc[31:0]  = a;
`ifdef MDU_MADD_EN
      4'd7: begin acc = acc + 64'(ps); cyc = MC; end
      4'd8: begin acc = acc + pu;      cyc = MC; end
      4'd9: begin acc = acc - 64'(ps); cyc = MC; end
`endif
      default: ;
    endcase
    {hi_o, lo_o} = acc;
  endfunction

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  initial begin
    int c;
    logic [31:0] m_hi, m_lo, e_hi, e_lo;
    int e_cyc;

    reset = 1'b1; Start = 1'b0; MDCtrl = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b0;

    //   op     a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
    add(4'd1, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, MC);
    add(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFE, 32'h00000001, MC);
    add(4'd3, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    add(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5,        32'h6,        32'd0,        32'h80000000, DC);
    add(4'd4, 32'd5,        32'd0,        32'h11,       32'h22,       32'h11,       32'h22,       DC);
    add(4'd3, 32'hFFFFFFF9, 32'd0,        32'h5,        32'h6,        32'h5,        32'h6,        DC);
    add(4'd3, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFD, DC);
    add(4'd4, 32'd7,        32'd3,        32'd0,        32'd0,        32'd1,        32'd2,        DC);
    add(4'd5, 32'h1234,     32'd0,        32'd0,        32'd0,        32'h1234,     32'd0,        0);
    add(4'd6, 32'h5678,     32'd0,        32'hAA,       32'hBB,       32'hAA,       32'h5678,     0);
    add(4'd0, 32'h9,        32'h9,        32'h1,        32'h2,        32'h1,        32'h2,        0);
    add(4'd12, 32'h9,       32'h9,        32'h1,        32'h2,        32'h1,        32'h2,        0);
`ifdef MDU_MADD_EN
    add(4'd8, 32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 32'd1,        32'd0,        MC);
    add(4'd9, 32'd2,        32'd3,        32'd0,        32'd4,        32'hFFFFFFFF, 32'hFFFFFFFE, MC);
`else
    add(4'd8, 32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 0);
    add(4'd9, 32'd2,        32'd3,        32'd0,        32'd4,        32'd0,        32'd4,        0);
`endif

    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, c);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(c), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
    end

    // Start pulses during RUN (mult with new operands, then mthi) are ignored.
    set_hilo(32'd0, 32'd0);
    @(negedge clk);
    MDCtrl = 4'd1; A = 32'd3; B = 32'd4; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDCtrl = 4'd0;
    c = 0;
    while (Busy && c < 100) begin
      c++;
      if (c == 2) begin Start = 1'b1; MDCtrl = 4'd1; A = 32'd100; B = 32'd100; end
      else if (c == 3) begin Start = 1'b1; MDCtrl = 4'd5; A = 32'hDEAD; end
      else begin Start = 1'b0; MDCtrl = 4'd0; end
      @(negedge clk);
    end
    Start = 1'b0; MDCtrl = 4'd0;
    chk("busy_start_cycles", 32'(c), 32'(MC));
    chk("busy_start_hi", HI, 32'd0);
    chk("busy_start_lo", LO, 32'd12);

    // Reset in the third busy cycle of a divide: cleared, no late commit.
    set_hilo(32'h55, 32'h66);
    @(negedge clk);
    MDCtrl = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDCtrl = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {31'd0, Busy}, 32'd0);
    chk("midreset_hi", HI, 32'd0);
    chk("midreset_lo", LO, 32'd0);
    repeat (DC + 4) @(negedge clk);
    chk("midreset_late_busy", {31'd0, Busy}, 32'd0);
    chk("midreset_late_hi", HI, 32'd0);
    chk("midreset_late_lo", LO, 32'd0);

    // Random ops against the reference model, HI/LO carried across ops.
    m_hi = 32'd0; m_lo = 32'd0;
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [3:0] op;
      logic [31:0] ra, rb;
      r  = $urandom_range(0, 21);
      op = (r < 16) ? 4'(r) : 4'(r - 15);
      ra = rand_opnd();
      rb = rand_opnd();
      model(op, ra, rb, m_hi, m_lo, e_hi, e_lo, e_cyc);
      run_op(op, ra, rb, c);
      chk($sformatf("rnd%0d_op%0d_cycles", n, op), 32'(c), 32'(e_cyc));
      chk($sformatf("rnd%0d_op%0d_hi a=%h b=%h", n, op, ra, rb), HI, e_hi);
      chk($sformatf("rnd%0d_op%0d_lo a=%h b=%h", n, op, ra, rb), LO, e_lo);
      m_hi = e_hi; m_lo = e_lo;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, alongside the single-cycle ALU.
- Consumes a 4-bit operation code from the controller and the forwarded rs/rt operands. Holds the architectural HI/LO registers.
- Reports Busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu (and madd family when enabled); must be >= 1.
- DIV_CYCLES, 10: cycles Busy stays high for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- MDCtrl  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub (7-9 only with MDU_MADD_EN); 10-15 no-op
- Start  input  1  one-cycle qualifier: MDCtrl is valid this cycle
- Busy  output  1  operation in progress
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, Busy=0, counter=0, state IDLE. Reset in any state, including mid-operation, aborts the operation and applies these values on that edge. The pending result is discarded.
- States: IDLE, RUN.
- IDLE, Start=1 with a mult/div-class op (1-4, or 7-9 when enabled):
  - Latch A, B, op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. Busy=1 from the next cycle.
- IDLE, Start=1 with mthi (5): HI<=A at that edge. mtlo (6): LO<=A. Busy stays 0. Zero latency.
- RUN: counter decrements each cycle. On the cycle counter==1:
  - Commit the result to HI/LO at that edge.
  - Busy=0 and state IDLE from the next cycle.
  - Total: Busy high for exactly N cycles. HI/LO are readable on the first cycle Busy is low again.
- Start while Busy=1 is ignored; operands and HI/LO are unaffected. The hazard unit guarantees this never happens, but the behaviour is fixed regardless.
- HI/LO outputs always show committed values. No intermediate values are visible during RUN.
- Arithmetic:
  - mult: {HI,LO} = signed(A) * signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): the full DIV_CYCLES busy period still elapses. HI/LO are left unchanged.
- Start with MDCtrl 0 or 10-15 (or 7-9 without the macro): no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 7 madd: {HI,LO} += signed product.
  - op 8 maddu: {HI,LO} += unsigned product.
  - op 9 msub: {HI,LO} -= signed product.
  - All use MULT_CYCLES latency. 64-bit arithmetic wraps modulo 2^64. The accumulator base is the {HI,LO} value latched at Start.
- Undefined: ops 7-9 are no-ops (Busy stays 0, HI/LO unchanged), and no accumulate adder is synthesized.

Test Plan:
- Reset, then Start op1 A=0xFFFFFFFE B=3 -> Busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Start op2 A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Start op3 A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Op3 A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0. Op4 A=5 B=0 with HI=0x11 LO=0x22 -> Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Op5 A=0x1234 -> HI=0x1234 next cycle, Busy never rises. Start op1 during RUN with different operands -> ignored; first result committed.
- Reset asserted at cycle 3 of div -> Busy=0, HI=LO=0 next cycle, no late commit. With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, op8 A=1 B=1 -> HI=1, LO=0.
